permute_result_accumulator: RTL and testbench

- Downstream consumer of the full-permutation pipeline output stream.
- Each 64-bit result word carries: ECC status in bit 63, a 13-bit pcoeff count in [60:48], and a 48-bit summed value in [47:0].
- Per top, the block accumulates a software-programmed number of per-bot results into one total (sum, pcoeff count, ECC error count).
- It presents that total to the host-side result writer over a valid/ready handshake.

---
 rtl/permute_result_pkg.sv | 16 +
 rtl/permute_result_adder.sv | 39 +++
 rtl/permute_result_accumulator.sv | 109 ++++++++++
 tb/tb_permute_result_accumulator.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/permute_result_pkg.sv
// permute_result_pkg: result word layout and FSM states shared by the permute result accumulator
package permute_result_pkg;
    localparam int ECC_BIT    = 63;
    localparam int PCOEFF_LSB = 48;
    localparam int PCOEFF_W   = 13;
    localparam int SUM_W      = 48;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, EMIT} state_t;

    typedef struct packed {
        logic                ecc;
        logic [1:0]          rsvd;
        logic [PCOEFF_W-1:0] pcoeff;
        logic [SUM_W-1:0]    sum;
    } result_t;
endpackage

// File: rtl/permute_result_adder.sv
// permute_result_adder: registered sum/count accumulators with a sticky carry-out flag
module permute_result_adder
    import permute_result_pkg::*;
#(
    parameter int SUM_WIDTH   = 64,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   clear,
    input  logic                   add,
    input  logic [SUM_W-1:0]       sum_in,
    input  logic [PCOEFF_W-1:0]    pcoeff_in,
    output logic [SUM_WIDTH-1:0]   total_sum,
    output logic [COUNT_WIDTH-1:0] total_count,
    output logic                   overflow
);
    logic [SUM_WIDTH:0]   sum_next;
    logic [COUNT_WIDTH:0] count_next;

    assign sum_next   = {1'b0, total_sum} + {{(SUM_WIDTH + 1 - SUM_W){1'b0}}, sum_in};
    assign count_next = {1'b0, total_count} + {{(COUNT_WIDTH + 1 - PCOEFF_W){1'b0}}, pcoeff_in};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            total_sum   <= '0;
            total_count <= '0;
            overflow    <= 1'b0;
        end else if (clear) begin
            total_sum   <= '0;
            total_count <= '0;
            overflow    <= 1'b0;
        end else if (add) begin
            total_sum   <= sum_next[SUM_WIDTH-1:0];
            total_count <= count_next[COUNT_WIDTH-1:0];
            overflow    <= overflow | sum_next[SUM_WIDTH] | count_next[COUNT_WIDTH];
        end
    end
endmodule

// File: rtl/permute_result_accumulator.sv
// permute_result_accumulator: per-top batch totalizer; PERMUTE_RESULT_ECC_ABORT_EN enables ECC abort/drain
module permute_result_accumulator
    import permute_result_pkg::*;
#(
    parameter int SUM_WIDTH     = 64,
    parameter int COUNT_WIDTH   = 32,
    parameter int BATCH_WIDTH   = 32,
    parameter int ECC_CNT_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     start,
    input  logic [BATCH_WIDTH-1:0]   batchSize,
    output logic                     busy,
    input  logic                     ivalid,
    output logic                     oready,
    input  logic [63:0]              summedDataPcoeffCountIn,
    output logic                     ovalid,
    input  logic                     iready,
    output logic [SUM_WIDTH-1:0]     totalSum,
    output logic [COUNT_WIDTH-1:0]   totalPcoeffCount,
    output logic [ECC_CNT_WIDTH-1:0] eccErrorCount,
    output logic                     sumOverflow,
    output logic                     eccAbort
);
    state_t                 state, state_next;
    result_t                word;
    logic [BATCH_WIDTH-1:0] batch_q, received, rcv_next;
    logic                   xfer, last, take, clear, unused_rsvd;

    assign word        = summedDataPcoeffCountIn;
    assign unused_rsvd = ^word.rsvd;
    assign oready      = state == ACCUM || state == DRAIN;
    assign ovalid      = state == EMIT;
    assign busy        = state != IDLE;
    assign xfer        = ivalid && oready;
    assign rcv_next    = received + BATCH_WIDTH'(1);
    assign last        = rcv_next == batch_q;
    assign clear       = state == IDLE && start;

`ifdef PERMUTE_RESULT_ECC_ABORT_EN
    assign take = xfer && state == ACCUM && !word.ecc;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = batchSize == '0 ? EMIT : ACCUM;
            ACCUM: if (xfer && (last || word.ecc)) state_next = last ? EMIT : DRAIN;
            DRAIN: if (xfer && last) state_next = EMIT;
            EMIT:  if (iready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) eccAbort <= 1'b0;
        else if (clear) eccAbort <= 1'b0;
        else if (xfer && state == ACCUM && word.ecc) eccAbort <= 1'b1;
    end
`else
    assign take     = xfer;
    assign eccAbort = 1'b0;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = batchSize == '0 ? EMIT : ACCUM;
            ACCUM: if (xfer && last) state_next = EMIT;
            EMIT:  if (iready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            batch_q       <= '0;
            received      <= '0;
            eccErrorCount <= '0;
        end else begin
            state <= state_next;
            if (clear) begin
                batch_q       <= batchSize;
                received      <= '0;
                eccErrorCount <= '0;
            end else if (xfer) begin
                received <= rcv_next;
                if (word.ecc && !(&eccErrorCount))
                    eccErrorCount <= eccErrorCount + ECC_CNT_WIDTH'(1);
            end
        end
    end

    permute_result_adder #(
        .SUM_WIDTH  (SUM_WIDTH),
        .COUNT_WIDTH(COUNT_WIDTH)
    ) u_adder (
        .clock      (clock),
        .resetn     (resetn),
        .clear      (clear),
        .add        (take),
        .sum_in     (word.sum),
        .pcoeff_in  (word.pcoeff),
        .total_sum  (totalSum),
        .total_count(totalPcoeffCount),
        .overflow   (sumOverflow)
    );
endmodule

// File: tb/tb_permute_result_accumulator.sv
// tb_permute_result_accumulator: randomized scoreboard bench against an exact-arithmetic batch model
module tb_permute_result_accumulator;
    localparam int SW = 48, CW = 32, BW = 32, EW = 16;

    logic          clock = 0, resetn = 1, start = 0, ivalid = 0, iready = 1;
    logic [BW-1:0] batchSize = '0;
    logic [63:0]   din = '0;
    logic          busy, oready, ovalid, sumOverflow, eccAbort;
    logic [SW-1:0] totalSum;
    logic [CW-1:0] totalPcoeffCount;
    logic [EW-1:0] eccErrorCount;

    typedef struct {
        logic [SW-1:0] sum;
        logic [CW-1:0] cnt;
        logic [EW-1:0] ecc;
        logic          ovf;
        logic          abort;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   tests = 0, fails = 0;
    bit   rand_ready = 0, hold_ready = 1;

    permute_result_accumulator #(.SUM_WIDTH(SW)) dut (
        .clock                  (clock),
        .resetn                 (resetn),
        .start                  (start),
        .batchSize              (batchSize),
        .busy                   (busy),
        .ivalid                 (ivalid),
        .oready                 (oready),
        .summedDataPcoeffCountIn(din),
        .ovalid                 (ovalid),
        .iready                 (iready),
        .totalSum               (totalSum),
        .totalPcoeffCount       (totalPcoeffCount),
        .eccErrorCount          (eccErrorCount),
        .sumOverflow            (sumOverflow),
        .eccAbort               (eccAbort)
    );

    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        #1 iready = rand_ready ? ($urandom_range(0, 1) == 1) : hold_ready;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk(input bit e, input logic [12:0] pc, input logic [47:0] s);
        return {e, 2'b10, pc, s};
    endfunction

    // Exact-width totals: any carry-out during a batch means the exact sum reached 2^width.
    function automatic exp_t model(input logic [63:0] ws[$]);
        exp_t r;
        logic [79:0] s = '0, c = '0;
        int e = 0;
        bit ab = 0, drop;
        foreach (ws[i]) begin
            drop = 0;
`ifdef PERMUTE_RESULT_ECC_ABORT_EN
            if (ab || ws[i][63]) begin
                drop = 1;
                ab = 1;
            end
`endif
            if (!drop) begin
                s += 80'(ws[i][47:0]);
                c += 80'(ws[i][60:48]);
            end
            if (ws[i][63] && e < 65535) e++;
        end
        r.sum = s[SW-1:0];
        r.cnt = c[CW-1:0];
        r.ecc = EW'(e);
        r.ovf = (s >> SW) != 0 || (c >> CW) != 0;
        r.abort = ab;
        return r;
    endfunction

    always @(negedge clock) begin
        if (resetn && ovalid && iready) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got sum %h with no expected total queued", totalSum);
            end else begin
                mon_e = sbq.pop_front();
                chk("total_sum", 64'(totalSum), 64'(mon_e.sum));
                chk("total_pcoeff", 64'(totalPcoeffCount), 64'(mon_e.cnt));
                chk("ecc_count", 64'(eccErrorCount), 64'(mon_e.ecc));
                chk("sum_overflow", 64'(sumOverflow), 64'(mon_e.ovf));
                chk("ecc_abort", 64'(eccAbort), 64'(mon_e.abort));
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        @(negedge clock);
        while (busy && k < 500) begin
            @(negedge clock);
            k++;
        end
        if (busy) chk("idle_timeout", 64'(busy), 64'(0));
    endtask

    task automatic send(input logic [63:0] w, input bit gap, input bit is_last);
        int k = 0;
        if (gap) begin
            ivalid = 0;
            @(negedge clock);
        end
        ivalid = 1;
        din = w;
        while (!oready && k < 200) begin
            @(negedge clock);
            k++;
        end
        if (!oready) begin
            chk("send_timeout", 64'(oready), 64'(1));
            ivalid = 0;
            return;
        end
        @(negedge clock);
        if (is_last) begin
            ivalid = 0;
            chk("ovalid_latency", 64'(ovalid), 64'(1));
            chk("oready_in_emit", 64'(oready), 64'(0));
        end
    endtask

    task automatic run_batch(input logic [63:0] ws[$], input bit gap);
        sbq.push_back(model(ws));
        wait_idle();
        start = 1;
        batchSize = BW'(ws.size());
        @(negedge clock);
        start = 0;
        if (ws.size() == 0) begin
            chk("zero_batch_ovalid", 64'(ovalid), 64'(1));
            chk("zero_batch_oready", 64'(oready), 64'(0));
        end
        foreach (ws[i]) send(ws[i], gap, i == ws.size() - 1);
    endtask

    initial begin
        logic [63:0] q[$];
        logic [SW-1:0] snap;
        int k;
        #1 resetn = 0;
        #1;
        chk("rst_ovalid", 64'(ovalid), 64'(0));
        chk("rst_oready", 64'(oready), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_totals", {totalSum, eccErrorCount}, 64'(0));
        chk("rst_flags", {totalPcoeffCount, sumOverflow, eccAbort}, 64'(0));
        repeat (2) @(negedge clock);
        resetn = 1;

        q.delete();
        for (int i = 1; i <= 4; i++) q.push_back(mk(0, 13'(i), 48'(10 * i)));
        run_batch(q, 0);

        hold_ready = 0;
        q.delete();
        for (int i = 1; i <= 3; i++) q.push_back(mk(0, 13'(i), 48'(100 + i)));
        run_batch(q, 1);
        snap = totalSum;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("bp_hold", {ovalid, oready, totalSum}, {1'b1, 1'b0, snap});
        end
        hold_ready = 1;
        repeat (3) @(negedge clock);
        chk("bp_busy_after", 64'(busy), 64'(0));

        q.delete();
        run_batch(q, 0);

        q.delete();
        q.push_back(mk(0, 0, 48'hFFFF_FFFF_FFFF));
        q.push_back(mk(0, 0, 48'h2));
        run_batch(q, 0);
        q.delete();
        q.push_back(mk(0, 0, 48'd5));
        run_batch(q, 0);

        q.delete();
        q.push_back(mk(0, 13'd1, 48'd1));
        q.push_back(mk(0, 13'd1, 48'd1));
        q.push_back(mk(1, 13'd1, 48'd7));
        q.push_back(mk(0, 13'd1, 48'd1));
        run_batch(q, 0);

        wait_idle();
        start = 1;
        batchSize = 5;
        @(negedge clock);
        start = 0;
        send(mk(0, 1, 48'd9), 0, 0);
        send(mk(0, 1, 48'd9), 0, 0);
        resetn = 0;
        ivalid = 0;
        #1;
        chk("midrst_ovalid", 64'(ovalid), 64'(0));
        chk("midrst_oready", 64'(oready), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        @(negedge clock);
        resetn = 1;
        q.delete();
        q.push_back(mk(0, 0, 48'd3));
        q.push_back(mk(0, 0, 48'd3));
        run_batch(q, 0);

        rand_ready = 1;
        repeat (25) begin
            q.delete();
            k = $urandom_range(0, 8);
            for (int i = 0; i < k; i++)
                q.push_back(mk($urandom_range(0, 7) == 0, 13'($urandom), {16'($urandom), 32'($urandom)}));
            run_batch(q, $urandom_range(0, 1) == 1);
        end
        rand_ready = 0;
        hold_ready = 1;
        k = 0;
        while (sbq.size() != 0 && k < 200) begin
            @(negedge clock);
            k++;
        end
        chk("scoreboard_drained", 64'(sbq.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
